bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single Bridge bus port (DRAM and memory-mapped peripherals).
- Master 0 is the CPU MEM stage (lw/sw). Master 1 is a secondary agent such as a DMA or debug loader.
- Grants by round-robin, latches the winning request and drives Bus_addr/Bus_wen/Bus_wdata for the access.
- Captures Bus_rdata after a fixed slave latency and returns it with a one-cycle ack pulse. CPU stall = m0_req & ~m0_ack.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master round-robin arbiter and sequencer for the single Bridge bus
//   port. Master 0 is the CPU MEM stage, master 1 a secondary agent
//   (DMA / debug loader). The winning request is latched at grant, driven
//   onto the bus for the access, and completed with a one-cycle ack pulse.
//
//   Parameters
//     AW      address width
//     DW      data width
//     RD_LAT  slave read latency in cycles (1..15); writes take one cycle
//
//   Ports
//     cpu_clk, cpu_rst         clock, async active-high reset
//     m0_req/addr/wen/wdata    master 0 request (held until m0_ack)
//     m0_ack, m0_rdata         master 0 completion pulse and read data
//     m1_*                     same set for master 1
//     m1_lock                  (BUS_ARB_LOCK_EN only) m1 bus lock
//     Bus_addr/wen/wdata       access to the Bridge
//     Bus_rdata                read data from the Bridge
//     busy                     high whenever the FSM is not in IDLE
//
//   Optional feature macro: BUS_ARB_LOCK_EN
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | no transaction, arbitrate incoming requests
// ACCESS | bus driven from latched request; reads wait RD_LAT cycles
// RESP   | one-cycle ack (and read data) to the granted master
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wen,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wen,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
`ifdef BUS_ARB_LOCK_EN
    input  logic          m1_lock,
`endif
    output logic [AW-1:0] Bus_addr,
    output logic          Bus_wen,
    output logic [DW-1:0] Bus_wdata,
    input  logic [DW-1:0] Bus_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(RD_LAT - 1);

    state_t        state;
    logic          last_gnt;
    logic          gnt;
    logic          wen_q;
    logic [3:0]    cnt;

    logic          pick_m1;
    logic          hold_last;
    logic [AW-1:0] sel_addr;
    logic          sel_wen;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] rd_val;

    always_comb begin
        pick_m1   = 1'b0;
        hold_last = 1'b0;
        if (m0_req && m1_req)
            pick_m1 = ~last_gnt;
        else
            pick_m1 = m1_req;
`ifdef BUS_ARB_LOCK_EN
        // A locked m1 wins outright and does not consume its round-robin turn.
        if (m1_lock && m1_req)
            pick_m1 = 1'b1;
        hold_last = m1_lock && pick_m1;
`endif
    end

    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wen   = pick_m1 ? m1_wen   : m0_wen;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    assign rd_val    = wen_q ? '0 : Bus_rdata;

    // Bus_addr/Bus_wdata double as the latched request address/data.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            wen_q     <= 1'b0;
            cnt       <= '0;
            Bus_addr  <= '0;
            Bus_wen   <= 1'b0;
            Bus_wdata <= '0;
            busy      <= 1'b0;
            m0_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_ack    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt       <= pick_m1;
                        if (!hold_last)
                            last_gnt <= pick_m1;
                        wen_q     <= sel_wen;
                        cnt       <= '0;
                        Bus_addr  <= sel_addr;
                        Bus_wen   <= sel_wen;
                        Bus_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe lasts only the first ACCESS cycle.
                    Bus_wen <= 1'b0;
                    if (wen_q || (cnt == CNT_LAST)) begin
                        Bus_addr  <= '0;
                        Bus_wdata <= '0;
                        if (gnt) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= rd_val;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= rd_val;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    m0_ack   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_rdata <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int RD_LAT = 3;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        m0_req = 0, m0_wen = 0, m1_req = 0, m1_wen = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        lock_drv = 0;
    logic [31:0] Bus_rdata = 0;
    logic        m0_ack, m1_ack, Bus_wen, busy;
    logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 cpu_clk = ~cpu_clk;

    bus_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wen   (m0_wen),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wen   (m1_wen),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
`ifdef BUS_ARB_LOCK_EN
        .m1_lock  (lock_drv),
`endif
        .Bus_addr (Bus_addr),
        .Bus_wen  (Bus_wen),
        .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction described by
    // its first ACCESS cycle and ACCESS length; outputs derive from cycle number.
    int          cyc = 0;
    bit          g_valid = 0;
    int          g_m = 0;
    int          g_start = 0;
    int          g_len = 0;
    logic [31:0] g_addr = 0, g_wdata = 0, g_rdata = 0;
    logic        g_wen = 0;
    int          m_last = 1;
    logic        ack_seen0 = 0, ack_seen1 = 0;

    always @(posedge cpu_clk) begin
        if (cpu_rst) begin
            g_valid = 0;
            m_last  = 1;
        end else begin
            if (g_valid && !g_wen && cyc == g_start + g_len - 1)
                g_rdata = Bus_rdata;
            if ((!g_valid || cyc > g_start + g_len) && (m0_req || m1_req)) begin
                int  w;
                bit  locked;
                locked = LOCK_EN && lock_drv && m1_req;
                if (locked)               w = 1;
                else if (m0_req && m1_req) w = 1 - m_last;
                else                      w = m1_req ? 1 : 0;
                g_valid = 1;
                g_m     = w;
                g_addr  = w ? m1_addr  : m0_addr;
                g_wdata = w ? m1_wdata : m0_wdata;
                g_wen   = w ? m1_wen   : m0_wen;
                g_len   = g_wen ? 1 : RD_LAT;
                g_start = cyc + 1;
                g_rdata = 0;
                if (!locked) m_last = w;
            end
        end
        cyc++;
    end

    always @(negedge cpu_clk) begin
        if (!cpu_rst) begin
            bit          acc, rsp;
            logic [31:0] e_rd;
            acc  = g_valid && cyc >= g_start && cyc < g_start + g_len;
            rsp  = g_valid && cyc == g_start + g_len;
            e_rd = g_wen ? 32'h0 : g_rdata;
            chk("busy", busy, acc | rsp);
            chk("bus_wen", Bus_wen, acc && g_wen && cyc == g_start);
            chk("m0_ack", m0_ack, rsp && g_m == 0);
            chk("m1_ack", m1_ack, rsp && g_m == 1);
            chk("m0_rdata", m0_rdata, (rsp && g_m == 0) ? e_rd : 32'h0);
            chk("m1_rdata", m1_rdata, (rsp && g_m == 1) ? e_rd : 32'h0);
            if (acc) begin
                chk("bus_addr", Bus_addr, g_addr);
                chk("bus_wdata", Bus_wdata, g_wdata);
            end else if (!rsp) begin
                chk("bus_addr_idle", Bus_addr, 32'h0);
                chk("bus_wdata_idle", Bus_wdata, 32'h0);
            end
        end
        ack_seen0 = m0_ack;
        ack_seen1 = m1_ack;
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        #2 cpu_rst = 1'b1;
        repeat (2) @(negedge cpu_clk);
        #2 cpu_rst = 1'b0;
    endtask

    int ack_seq[8];

    // Collect n acks (bounded); optionally release m1 lock after a given count.
    task automatic collect(input int n, input int lock_drop_at);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            @(negedge cpu_clk);
            budget++;
            if (m0_ack || m1_ack) begin
                chk("ack_onehot", {31'h0, m0_ack & m1_ack}, 32'h0);
                ack_seq[got] = m1_ack ? 1 : 0;
                got++;
            end
            tick();
            if (got == lock_drop_at) lock_drv = 1'b0;
        end
        chk("ack_budget", got, n);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {m0_ack, m1_ack, Bus_wen}, 0);
        chk("rst_bus_addr", Bus_addr, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        repeat (2) @(negedge cpu_clk);
        #2 cpu_rst = 1'b0;
        repeat (3) tick();

        // single write from m0
        m0_req = 1; m0_wen = 1; m0_addr = 32'h8000_0010; m0_wdata = 32'hDEAD_BEEF;
        @(negedge cpu_clk);
        chk("wr_t_busy", busy, 0);
        @(negedge cpu_clk);
        chk("wr_t1_addr", Bus_addr, 32'h8000_0010);
        chk("wr_t1_wen", Bus_wen, 1);
        chk("wr_t1_wdata", Bus_wdata, 32'hDEAD_BEEF);
        chk("wr_t1_ack", m0_ack, 0);
        @(negedge cpu_clk);
        chk("wr_t2_wen", Bus_wen, 0);
        chk("wr_t2_ack", m0_ack, 1);
        tick();
        m0_req = 0;
        @(negedge cpu_clk);
        chk("wr_t3_ack", m0_ack, 0);
        repeat (2) tick();

        // single read from m1, RD_LAT=3
        m1_req = 1; m1_wen = 0; m1_addr = 32'h0000_0040;
        tick();
        Bus_rdata = 32'hAAAA_AAAA;
        @(negedge cpu_clk);
        chk("rd_t1_addr", Bus_addr, 32'h0000_0040);
        chk("rd_t1_wen", Bus_wen, 0);
        tick();
        tick();
        Bus_rdata = 32'h1234_5678;
        tick();
        Bus_rdata = 32'h5555_5555;
        @(negedge cpu_clk);
        chk("rd_t4_ack", m1_ack, 1);
        chk("rd_t4_rdata", m1_rdata, 32'h1234_5678);
        chk("rd_t4_m0ack", m0_ack, 0);
        tick();
        m1_req = 0;
        repeat (2) tick();

        // late arrival of m1 during an m0 read
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_0100;
        tick();
        tick();
        m1_req = 1; m1_wen = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'h0000_0077;
        @(negedge cpu_clk);
        chk("late_m0_addr", Bus_addr, 32'h0000_0100);
        tick();
        tick();
        @(negedge cpu_clk);
        chk("late_m0_ack", m0_ack, 1);
        chk("late_m1_ack0", m1_ack, 0);
        tick();
        m0_req = 0;
        @(negedge cpu_clk);
        chk("late_idle", busy, 0);
        tick();
        @(negedge cpu_clk);
        chk("late_m1_addr", Bus_addr, 32'h0000_0200);
        chk("late_m1_wen", Bus_wen, 1);
        tick();
        @(negedge cpu_clk);
        chk("late_m1_ack", m1_ack, 1);
        tick();
        m1_req = 0;
        repeat (2) tick();

        // reset in the middle of a read (cnt=1)
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_0300;
        tick();
        tick();
        @(negedge cpu_clk);
        #2 cpu_rst = 1'b1;
        m0_req = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_bus", Bus_addr | Bus_wdata, 0);
        chk("midrst_ctl", {m0_ack, m1_ack, Bus_wen}, 0);
        repeat (2) @(negedge cpu_clk);
        #2 cpu_rst = 1'b0;
        repeat (3) begin
            @(negedge cpu_clk);
            chk("postrst_busy", busy, 0);
            chk("postrst_ack", {m0_ack, m1_ack}, 0);
        end
        tick();
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_0400;
        m1_req = 1; m1_wen = 0; m1_addr = 32'h0000_0500;
        collect(1, -1);
        chk("postrst_first", ack_seq[0], 0);
        m0_req = 0; m1_req = 0;
        repeat (8) tick();

        // simultaneous continuous requests from reset
        m0_req = 1; m0_wen = 1; m0_addr = 32'h0000_1000; m0_wdata = 32'h0000_0001;
        m1_req = 1; m1_wen = 1; m1_addr = 32'h0000_2000; m1_wdata = 32'h0000_0002;
        do_reset();
        collect(4, -1);
        chk("rr_0", ack_seq[0], 0);
        chk("rr_1", ack_seq[1], 1);
        chk("rr_2", ack_seq[2], 0);
        chk("rr_3", ack_seq[3], 1);
        m0_req = 0; m1_req = 0;
        repeat (8) tick();

`ifdef BUS_ARB_LOCK_EN
        m0_req = 1; m1_req = 1;
        lock_drv = 1;
        do_reset();
        collect(4, 3);
        chk("lock_0", ack_seq[0], 1);
        chk("lock_1", ack_seq[1], 1);
        chk("lock_2", ack_seq[2], 1);
        chk("lock_release", ack_seq[3], 0);
        m0_req = 0; m1_req = 0; lock_drv = 0;
        repeat (8) tick();
`endif

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            Bus_rdata = $urandom;
            m0_addr = $urandom; m0_wdata = $urandom; m0_wen = $urandom_range(0, 1);
            m1_addr = $urandom; m1_wdata = $urandom; m1_wen = $urandom_range(0, 1);
            if (ack_seen0)                           m0_req = 0;
            else if (m0_req && $urandom_range(0, 15) == 0) m0_req = 0;
            else if (!m0_req && $urandom_range(0, 2) == 0) m0_req = 1;
            if (ack_seen1)                           m1_req = 0;
            else if (m1_req && $urandom_range(0, 15) == 0) m1_req = 0;
            else if (!m1_req && $urandom_range(0, 2) == 0) m1_req = 1;
            if (LOCK_EN) lock_drv = ($urandom_range(0, 7) == 0);
        end
        m0_req = 0; m1_req = 0; lock_drv = 0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
